vga_fb_slot_arbiter: RTL and testbench
======================================

Name: vga_fb_slot_arbiter

Overview:
Time-division arbiter sharing one single-port synchronous pixel RAM (RGB332) between VGA scanout and a pixel writer.
- Each 4-clock pixel period, tied to the pixel-enable strobe from the VGA timing block, reserves one slot for the display read.
- The remaining slots go to the writer through a valid/ready handshake.
- Sits between the VGA timing/colour output stage and the framebuffer RAM.

Parameters:
- ADDR_W, 19, RAM address width.
- DATA_W, 8, pixel width (RGB332: [7:5] red, [4:2] green, [1:0] blue).
- FB_DEPTH, 307200, number of valid pixels (640x480); scan address wraps here.

Ports:
- clock  in  1  system clock (4x pixel rate).
- reset  in  1  synchronous, active-high.
- pix_en  in  1  one-cycle strobe, nominally every 4th clock, from VGA timing.
- disp_active  in  1  current pixel lies inside the 640x480 visible area; sampled on pix_en.
- frame_start  in  1  one-cycle pulse; restarts scan address; sampled on pix_en.
- pix_data  out  DATA_W  pixel for the colour output stage.
- wr_valid  in  1  writer request.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_ready  out  1  writer grant; comb, independent of wr_valid.
- wr_err  out  1  one-cycle pulse: accepted write had wr_addr >= FB_DEPTH.
- ram_addr  out  ADDR_W  RAM address (comb mux).
- ram_we  out  1  RAM write enable (comb).
- ram_wdata  out  DATA_W  RAM write data (comb).
- ram_rdata  in  DATA_W  RAM read data; 1-clock latency.

Behaviour:
- Reset values: pix_data=0, wr_err=0, scan_addr=0, FSM=S_SYNC. wr_ready follows the FSM (1 in S_SYNC).
- FSM states:
  - S_SYNC: wait for the first pix_en; all cycles free to the writer.
  - S_DISP: pix_en cycle = phase 0.
  - S_CAPT: phase 1.
  - S_FREE: phases 2..3.
- Transitions:
  - pix_en in any state -> S_DISP on the same cycle (decode is comb on pix_en); S_DISP -> S_CAPT -> S_FREE.
  - S_FREE holds until pix_en. An early pix_en (period <4) resyncs; a late one extends S_FREE.
- S_DISP with disp_active=1:
  - Display read: ram_addr = (frame_start ? 0 : scan_addr), ram_we=0, wr_ready=0.
  - scan_addr <= used address + 1, or 0 if used address = FB_DEPTH-1.
- S_DISP with disp_active=0:
  - No read; wr_ready=1.
  - frame_start alone sets scan_addr <= 0.
- S_CAPT:
  - If the previous S_DISP read, pix_data <= ram_rdata; otherwise pix_data <= 0 (blanking).
  - wr_ready=1 in this state.
- Write slots:
  - A write is any cycle with wr_ready=1 and wr_valid=1: ram_addr=wr_addr, ram_wdata=wr_data, ram_we=(wr_addr<FB_DEPTH).
  - An out-of-range accept still completes the handshake (ram_we=0) and sets wr_err=1 next cycle.
- Throughput: at most 3 writes per active pixel period; every cycle during blanking.
- Latency: pix_data updates 1 clock after the pix_en that read it, and stays stable for the rest of the period.
- Writer bubble: when no write is granted, ram_addr = scan_addr, ram_we=0.
- Same-address collision (write one cycle after a read of that address): the display receives old data. No bypass.
- Reset mid-operation: returns to S_SYNC on the next edge. Any in-flight read is discarded and pix_data cleared.

Optional Feature:
- Macro: VGA_FB_STALL_CNT_EN.
- Defined:
  - Adds 16-bit output wr_stall_cnt, counting cycles with wr_valid=1 and wr_ready=0.
  - Saturates at 16'hFFFF; cleared by reset and by frame_start on pix_en.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package vga_pkg:
  - FSM state enum (S_SYNC, S_DISP, S_CAPT, S_FREE).
  - H_ACTIVE=640, V_ACTIVE=480, FB_DEPTH.
  - RGB332 field-slice constants.
- One natural sub-module: vga_fb_scan_addr (scan address counter with wrap and frame restart).

Test Plan:
1. Reset with wr_valid=1 held -> wr_ready=1 in S_SYNC; writes to addr 5, 6, 7 each take one clock; ram_we=1; pix_data=0.
2. pix_en every 4 clocks, disp_active=1, RAM preloaded (addr 0 = 8'hE0, addr 1 = 8'h1C) -> wr_ready low only on pix_en cycles; pix_data = E0, then 1C, each 1 clock after pix_en.
3. frame_start coincident with pix_en while scan_addr=1234 -> read uses addr 0; next active read uses addr 1.
4. scan_addr = FB_DEPTH-1 read -> next read at addr 0. Write to addr FB_DEPTH -> handshake completes, ram_we=0, wr_err pulses once.
5. pix_en arriving 2 clocks after the previous one -> FSM re-enters S_DISP immediately. disp_active=0 -> pix_data=0, and wr_ready=1 on the pix_en cycle.
6. With VGA_FB_STALL_CNT_EN, wr_valid held for 2 active pixel periods -> wr_stall_cnt=2; reset mid-frame -> cnt=0, pix_data=0, FSM S_SYNC.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the framebuffer slot arbiter.
//   - fb_state_e : slot FSM states (S_SYNC, S_DISP, S_CAPT, S_FREE)
//   - H_ACTIVE, V_ACTIVE, FB_DEPTH : visible raster geometry
//   - RGB332 field boundaries for the 8-bit pixel word
package vga_pkg;

    typedef enum logic [1:0] {
        S_SYNC = 2'd0,   // no pixel strobe seen yet, every cycle belongs to the writer
        S_DISP = 2'd1,   // phase 0: display read slot (only ever the decoded state)
        S_CAPT = 2'd2,   // phase 1: RAM data returns and is captured
        S_FREE = 2'd3    // phases 2..3: writer slots until the next strobe
    } fb_state_e;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int FB_DEPTH = H_ACTIVE * V_ACTIVE;

    // RGB332 field slices: [7:5] red, [4:2] green, [1:0] blue
    localparam int RGB_R_MSB = 7;
    localparam int RGB_R_LSB = 5;
    localparam int RGB_G_MSB = 4;
    localparam int RGB_G_LSB = 2;
    localparam int RGB_B_MSB = 1;
    localparam int RGB_B_LSB = 0;

endpackage

// File: rtl/vga_fb_scan_addr.sv
// vga_fb_scan_addr: display scan address counter.
//   clk_i        : system clock
//   rst_i        : synchronous active-high reset (address back to 0)
//   step_i       : a display read happens this cycle; advance past the used address
//   restart_i    : frame restart this cycle; the read (if any) uses address 0
//   scan_addr_o  : registered scan address (writer-bubble address)
//   used_addr_o  : address a display read uses this cycle (comb)
// The address wraps to 0 after FB_DEPTH-1.
module vga_fb_scan_addr
    import vga_pkg::*;
#(
    parameter int ADDR_W      = 19,
    parameter int FB_DEPTH_P  = FB_DEPTH
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              step_i,
    input  logic              restart_i,
    output logic [ADDR_W-1:0] scan_addr_o,
    output logic [ADDR_W-1:0] used_addr_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH_P - 1);

    logic [ADDR_W-1:0] scan_q;
    logic [ADDR_W-1:0] scan_d;

    always_comb begin
        used_addr_o = restart_i ? '0 : scan_q;
        scan_d      = scan_q;
        if (step_i) begin
            scan_d = (used_addr_o == LAST_ADDR) ? '0 : used_addr_o + 1'b1;
        end else if (restart_i) begin
            // frame restart during blanking: no read, just rewind
            scan_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scan_q <= '0;
        end else begin
            scan_q <= scan_d;
        end
    end

    assign scan_addr_o = scan_q;

endmodule

// File: rtl/vga_fb_slot_arbiter.sv
// vga_fb_slot_arbiter: time-division sharing of one single-port synchronous
// pixel RAM between VGA scanout and a pixel writer.
//   clock_i/reset_i   : system clock (4x pixel rate), synchronous active-high reset
//   pix_en_i          : pixel strobe from VGA timing; its cycle is the display slot
//   disp_active_i     : pixel is visible (sampled on pix_en_i)
//   frame_start_i     : rewind scan address (sampled on pix_en_i)
//   pix_data_o        : captured pixel for the colour stage (0 while blanking)
//   wr_valid_i/wr_addr_i/wr_data_i/wr_ready_o : writer handshake
//   wr_err_o          : one-cycle pulse after an accepted out-of-range write
//   ram_addr_o/ram_we_o/ram_wdata_o/ram_rdata_i : RAM port (1-clock read latency)
//   wr_stall_cnt_o    : only with VGA_FB_STALL_CNT_EN defined; saturating count of
//                       cycles with wr_valid_i=1 and wr_ready_o=0
module vga_fb_slot_arbiter
    import vga_pkg::*;
#(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 8,
    parameter int FB_DEPTH_P = FB_DEPTH
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              pix_en_i,
    input  logic              disp_active_i,
    input  logic              frame_start_i,
    output logic [DATA_W-1:0] pix_data_o,
    input  logic              wr_valid_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              wr_ready_o,
    output logic              wr_err_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_we_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i
`ifdef VGA_FB_STALL_CNT_EN
    ,
    output logic [15:0]       wr_stall_cnt_o
`endif
);

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(FB_DEPTH_P);

    fb_state_e         state_q, state_d, cur_state;
    logic              disp_rd;
    logic              rd_q;
    logic              wr_fire;
    logic              wr_in_range;
    logic              err_d, err_q;
    logic [DATA_W-1:0] pix_d, pix_q;
    logic [ADDR_W-1:0] scan_addr;
    logic [ADDR_W-1:0] used_addr;

    vga_fb_scan_addr #(
        .ADDR_W     (ADDR_W),
        .FB_DEPTH_P (FB_DEPTH_P)
    ) u_scan (
        .clk_i       (clock_i),
        .rst_i       (reset_i),
        .step_i      (disp_rd),
        .restart_i   (pix_en_i & frame_start_i),
        .scan_addr_o (scan_addr),
        .used_addr_o (used_addr)
    );

    // The strobe overrides the registered phase, so an early pix_en resyncs
    // immediately and a late one simply stretches S_FREE.
    always_comb begin
        cur_state = pix_en_i ? S_DISP : state_q;
        state_d   = state_q;
        disp_rd   = 1'b0;
        case (cur_state)
            S_SYNC:  state_d = S_SYNC;
            S_DISP: begin
                state_d = S_CAPT;
                disp_rd = disp_active_i;
            end
            S_CAPT:  state_d = S_FREE;
            S_FREE:  state_d = S_FREE;
            default: state_d = S_SYNC;
        endcase

        wr_ready_o  = ~disp_rd;
        wr_fire     = wr_ready_o & wr_valid_i;
        wr_in_range = ({1'b0, wr_addr_i} < DEPTH_W);
        err_d       = wr_fire & ~wr_in_range;

        ram_we_o    = 1'b0;
        ram_wdata_o = wr_data_i;
        if (disp_rd) begin
            ram_addr_o = used_addr;
        end else if (wr_fire) begin
            ram_addr_o = wr_addr_i;
            ram_we_o   = wr_in_range;
        end else begin
            ram_addr_o = scan_addr;
        end

        // Capture keys off the registered phase so a strobe landing in the
        // capture cycle still collects the data of the previous read.
        pix_d = pix_q;
        if (state_q == S_CAPT) begin
            pix_d = rd_q ? ram_rdata_i : '0;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= S_SYNC;
            rd_q    <= 1'b0;
            err_q   <= 1'b0;
            pix_q   <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= disp_rd;
            err_q   <= err_d;
            pix_q   <= pix_d;
        end
    end

    assign pix_data_o = pix_q;
    assign wr_err_o   = err_q;

`ifdef VGA_FB_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (pix_en_i && frame_start_i) begin
            stall_d = '0;
        end else if (wr_valid_i && !wr_ready_o && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign wr_stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_vga_fb_slot_arbiter.sv
module tb_vga_fb_slot_arbiter;

    localparam int AW = 19;
    localparam int DW = 8;
    localparam int FB = 1300;   // reduced depth so the wrap point is reachable

    logic          clk = 1'b0;
    logic          reset_i, pix_en_i, disp_active_i, frame_start_i;
    logic [DW-1:0] pix_data_o;
    logic          wr_valid_i;
    logic [AW-1:0] wr_addr_i;
    logic [DW-1:0] wr_data_i;
    logic          wr_ready_o, wr_err_o, ram_we_o;
    logic [AW-1:0] ram_addr_o;
    logic [DW-1:0] ram_wdata_o, ram_rdata_i;
`ifdef VGA_FB_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    always #5 clk = ~clk;

    vga_fb_slot_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FB_DEPTH_P(FB)) dut (
        .clock_i       (clk),
        .reset_i       (reset_i),
        .pix_en_i      (pix_en_i),
        .disp_active_i (disp_active_i),
        .frame_start_i (frame_start_i),
        .pix_data_o    (pix_data_o),
        .wr_valid_i    (wr_valid_i),
        .wr_addr_i     (wr_addr_i),
        .wr_data_i     (wr_data_i),
        .wr_ready_o    (wr_ready_o),
        .wr_err_o      (wr_err_o),
        .ram_addr_o    (ram_addr_o),
        .ram_we_o      (ram_we_o),
        .ram_wdata_o   (ram_wdata_o),
`ifdef VGA_FB_STALL_CNT_EN
        .wr_stall_cnt_o(stall_cnt),
`endif
        .ram_rdata_i   (ram_rdata_i)
    );

    // Single-port synchronous RAM, read-before-write
    logic [DW-1:0] mem     [0:2047];
    logic [DW-1:0] exp_mem [0:2047];
    always @(posedge clk) begin
        if (ram_we_o) mem[ram_addr_o[10:0]] <= ram_wdata_o;
        ram_rdata_i <= mem[ram_addr_o[10:0]];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    endtask

    // Scoreboard: expected pixel pushed on each strobe, popped when captured
    logic [DW-1:0] sb[$];
    int            exp_scan;
    logic          capt_due = 1'b0;

    always @(posedge clk) begin
        logic due;
        due      = capt_due && !reset_i;
        capt_due = pix_en_i && !reset_i;
        if (due) begin
            #1;
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL pix_capture: got %0h expected <no pending read>", pix_data_o);
            end else begin
                logic [DW-1:0] e;
                e = sb.pop_front();
                check("pix_data", {24'd0, pix_data_o}, {24'd0, e});
                $display("pix capture: pix_data=%02h expected=%02h", pix_data_o, e);
            end
        end
    end

    typedef struct {
        logic          pe, da, fs, wv;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          rdy, we;
        logic [AW-1:0] addr;
    } vec_t;

    function automatic vec_t mk(input logic pe, da, fs, wv, input int wa, input int wd,
                                input logic rdy, we, input int addr);
        vec_t v;
        v.pe = pe; v.da = da; v.fs = fs; v.wv = wv;
        v.wa = AW'(wa); v.wd = DW'(wd);
        v.rdy = rdy; v.we = we; v.addr = AW'(addr);
        return v;
    endfunction

    // Apply one cycle of stimulus (called at posedge+1), check comb outputs.
    task automatic drive(input vec_t v, input string nm);
        int used;
        pix_en_i = v.pe; disp_active_i = v.da; frame_start_i = v.fs;
        wr_valid_i = v.wv; wr_addr_i = v.wa; wr_data_i = v.wd;
        if (v.pe) begin
            used = v.fs ? 0 : exp_scan;
            if (v.da) begin
                sb.push_back(exp_mem[used]);
                exp_scan = (used == FB - 1) ? 0 : used + 1;
            end else begin
                sb.push_back('0);
                if (v.fs) exp_scan = 0;
            end
        end
        #4;
        check({nm, " wr_ready"}, {31'd0, wr_ready_o}, {31'd0, v.rdy});
        check({nm, " ram_we"},   {31'd0, ram_we_o},   {31'd0, v.we});
        check({nm, " ram_addr"}, {13'd0, ram_addr_o}, {13'd0, v.addr});
        if (v.we) begin
            check({nm, " ram_wdata"}, {24'd0, ram_wdata_o}, {24'd0, v.wd});
            exp_mem[v.wa[10:0]] = v.wd;
        end
        $display("%s: pe=%b da=%b fs=%b wv=%b wa=%0d | ready=%b we=%b addr=%0d",
                 nm, v.pe, v.da, v.fs, v.wv, v.wa, wr_ready_o, ram_we_o, ram_addr_o);
        @(posedge clk); #1;
        pix_en_i = 1'b0; frame_start_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(mk(0, 0, 0, 0, 0, 0, 1, 0, exp_scan), "idle");
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        pix_en_i = 1'b0; frame_start_i = 1'b0; disp_active_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        sb.delete();
        exp_scan = 0;
    endtask

    vec_t tbl[20];

    initial begin
        for (int i = 0; i < 2048; i++) exp_mem[i] = 8'(i * 37 + 3);
        exp_mem[0] = 8'hE0;
        exp_mem[1] = 8'h1C;
        for (int i = 0; i < 2048; i++) mem[i] = exp_mem[i];

        //         pe da fs wv  wa   wd     rdy we addr
        tbl[0]  = mk(0, 0, 0, 1,  5, 8'h11, 1, 1, 5);
        tbl[1]  = mk(0, 0, 0, 1,  6, 8'h22, 1, 1, 6);
        tbl[2]  = mk(0, 0, 0, 1,  7, 8'h33, 1, 1, 7);
        tbl[3]  = mk(0, 0, 0, 0,  0, 0,     1, 0, 0);
        tbl[4]  = mk(1, 1, 0, 1,  8, 8'h44, 0, 0, 0);   // read addr 0 -> E0
        tbl[5]  = mk(0, 0, 0, 1,  8, 8'h44, 1, 1, 8);
        tbl[6]  = mk(0, 0, 0, 1,  9, 8'h45, 1, 1, 9);
        tbl[7]  = mk(0, 0, 0, 0,  0, 0,     1, 0, 1);
        tbl[8]  = mk(1, 1, 0, 1, 10, 8'h46, 0, 0, 1);   // read addr 1 -> 1C
        tbl[9]  = mk(0, 0, 0, 1,  1, 8'h99, 1, 1, 1);   // collision: display keeps 1C
        tbl[10] = mk(0, 0, 0, 0,  0, 0,     1, 0, 2);
        tbl[11] = mk(0, 0, 0, 0,  0, 0,     1, 0, 2);
        tbl[12] = mk(1, 0, 0, 1, 11, 8'h55, 1, 1, 11);  // blanking strobe: writer wins
        tbl[13] = mk(0, 0, 0, 0,  0, 0,     1, 0, 2);
        tbl[14] = mk(1, 1, 0, 0,  0, 0,     0, 0, 2);   // early strobe (period 2)
        tbl[15] = mk(0, 0, 0, 0,  0, 0,     1, 0, 3);
        tbl[16] = mk(1, 1, 0, 0,  0, 0,     0, 0, 3);   // early again
        tbl[17] = mk(0, 0, 0, 0,  0, 0,     1, 0, 4);
        tbl[18] = mk(0, 0, 0, 0,  0, 0,     1, 0, 4);
        tbl[19] = mk(0, 0, 0, 0,  0, 0,     1, 0, 4);

        // Reset with the writer already requesting
        reset_i = 1'b1; pix_en_i = 1'b0; disp_active_i = 1'b0; frame_start_i = 1'b0;
        wr_valid_i = 1'b1; wr_addr_i = AW'(5); wr_data_i = 8'h11;
        exp_scan = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset pix_data", {24'd0, pix_data_o}, 32'd0);
        check("reset wr_err",   {31'd0, wr_err_o},   32'd0);
        check("reset wr_ready", {31'd0, wr_ready_o}, 32'd1);
        reset_i = 1'b0;

        foreach (tbl[i]) drive(tbl[i], $sformatf("vec%0d", i));
        check("collision ram kept write", {24'd0, mem[1]}, 32'h99);

        // Frame restart while scan address sits at 1234
        while (exp_scan != 1234) drive(mk(1, 1, 0, 0, 0, 0, 0, 0, exp_scan), "fill");
        idle(3);
        drive(mk(1, 1, 1, 0, 0, 0, 0, 0, 0), "frame_start read");
        idle(3);
        drive(mk(1, 1, 0, 0, 0, 0, 0, 0, 1), "after restart read");
        idle(3);

        // Wrap at the last pixel
        while (exp_scan != FB - 1) drive(mk(1, 1, 0, 0, 0, 0, 0, 0, exp_scan), "fill");
        idle(3);
        drive(mk(1, 1, 0, 0, 0, 0, 0, 0, FB - 1), "last read");
        idle(3);
        drive(mk(1, 1, 0, 0, 0, 0, 0, 0, 0), "wrapped read");

        // Out-of-range and last-valid writes
        drive(mk(0, 0, 0, 1, FB, 8'h77, 1, 0, FB), "oor write");
        check("wr_err pulse", {31'd0, wr_err_o}, 32'd1);
        drive(mk(0, 0, 0, 1, FB - 1, 8'h78, 1, 1, FB - 1), "last write");
        check("wr_err clear", {31'd0, wr_err_o}, 32'd0);
        idle(2);

        // Stall counting and reset mid-frame
        do_reset();
        reset_i = 1'b0;
        drive(mk(1, 1, 1, 0, 0, 0, 0, 0, 0), "s6 fs read");
        idle(3);
        for (int p = 0; p < 2; p++) begin
            drive(mk(1, 1, 0, 1, 20, 8'hA0 + p, 0, 0, exp_scan), "s6 stall");
            for (int k = 0; k < 3; k++)
                drive(mk(0, 0, 0, 1, 20, 8'hA0 + p, 1, 1, 20), "s6 write");
        end
`ifdef VGA_FB_STALL_CNT_EN
        check("stall_cnt two periods", {16'd0, stall_cnt}, 32'd2);
`endif
        drive(mk(1, 1, 0, 1, 20, 8'hB0, 0, 0, exp_scan), "s6 pre-reset read");
        check("pre-reset pix_data", {24'd0, pix_data_o}, {24'd0, exp_mem[2]});
        do_reset();
        check("mid reset pix_data", {24'd0, pix_data_o}, 32'd0);
        check("mid reset wr_err",   {31'd0, wr_err_o},   32'd0);
        wr_valid_i = 1'b0;
        #4;
        check("mid reset wr_ready", {31'd0, wr_ready_o}, 32'd1);
        check("mid reset ram_addr", {13'd0, ram_addr_o}, 32'd0);
`ifdef VGA_FB_STALL_CNT_EN
        check("mid reset stall_cnt", {16'd0, stall_cnt}, 32'd0);
`endif
        @(posedge clk); #1;
        reset_i = 1'b0;
        idle(2);
        check("sync state pix_data", {24'd0, pix_data_o}, 32'd0);
        check("scoreboard drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
